// File: rtl/ooop_pkg.sv
// Shared out-of-order core parameters used by the commit/retire slice.
package ooop_pkg;

    localparam int N_PHYS_REGS = 64;
    localparam int PREG_W      = $clog2(N_PHYS_REGS);
    localparam int ROB_TAG_W   = 5;

    // ROB tags are a modular sequence; the successor wraps at 2^ROB_TAG_W.
    function automatic logic [ROB_TAG_W-1:0] next_rob_tag(input logic [ROB_TAG_W-1:0] tag);
        return tag + ROB_TAG_W'(1);
    endfunction

endpackage

// File: rtl/free_tag_fifo.sv
// Registered FIFO returning freed physical register tags to the free list.
module free_tag_fifo #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic [AW:0]      count_next;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    // Head is forced to zero when nothing is queued so reset/drained state is clean.
    assign pop_data = empty ? '0 : mem[rd_ptr_reg];

    always_comb begin
        count_next = count_reg;
        if (push_ok && !pop_ok) begin
            count_next = count_reg + 1'b1;
        end else if (pop_ok && !push_ok) begin
            count_next = count_reg - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

endmodule

// File: rtl/commit_retire.sv
// Retire stage: counts commits, checks ROB order, and returns freed registers.
module commit_retire
    import ooop_pkg::*;
#(
    parameter int FREE_Q_DEPTH = 4,
    parameter int CNT_W        = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush_i,
    input  logic                 commit_valid_i,
    output logic                 commit_ready_o,
    input  logic [ROB_TAG_W-1:0] commit_tag_i,
    input  logic                 commit_rd_used_i,
    input  logic [PREG_W-1:0]    commit_dest_new_i,
    input  logic [PREG_W-1:0]    commit_dest_old_i,
    output logic                 free_valid_o,
    input  logic                 free_ready_i,
    output logic [PREG_W-1:0]    free_tag_o,
    output logic [CNT_W-1:0]     retire_count_o,
    output logic                 last_valid_o,
    output logic [ROB_TAG_W-1:0] last_tag_o,
    output logic [PREG_W-1:0]    last_dest_o,
    output logic                 order_err_o
);

    logic                 q_full;
    logic                 q_empty;
    logic                 accept;
    logic                 push;
    logic                 pop;
    logic [CNT_W-1:0]     count_reg;
    logic [ROB_TAG_W-1:0] exp_tag_reg;
    logic                 last_valid_reg;
    logic [ROB_TAG_W-1:0] last_tag_reg;
    logic [PREG_W-1:0]    last_dest_reg;
    logic                 order_err_reg;

    // A full queue blocks even when it is draining this cycle, keeping ready off the pop path.
    assign commit_ready_o = ~rst & ~flush_i & ~q_full;
    assign accept         = commit_valid_i & commit_ready_o;
    assign push           = accept & commit_rd_used_i & (commit_dest_old_i != '0);
    assign free_valid_o   = ~q_empty;
    assign pop            = free_valid_o & free_ready_i;

    free_tag_fifo #(
        .WIDTH (PREG_W),
        .DEPTH (FREE_Q_DEPTH)
    ) u_free_q (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (commit_dest_old_i),
        .pop       (pop),
        .pop_data  (free_tag_o),
        .full      (q_full),
        .empty     (q_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg      <= '0;
            exp_tag_reg    <= '0;
            last_valid_reg <= 1'b0;
            last_tag_reg   <= '0;
            last_dest_reg  <= '0;
            order_err_reg  <= 1'b0;
        end else if (flush_i) begin
            exp_tag_reg    <= '0;
            last_valid_reg <= 1'b0;
        end else if (accept) begin
            count_reg      <= count_reg + 1'b1;
            exp_tag_reg    <= next_rob_tag(commit_tag_i);
            last_valid_reg <= 1'b1;
            last_tag_reg   <= commit_tag_i;
            if (commit_rd_used_i) begin
                last_dest_reg <= commit_dest_new_i;
            end
            if (commit_tag_i != exp_tag_reg) begin
                order_err_reg <= 1'b1;
            end
        end
    end

    assign retire_count_o = count_reg;
    assign last_valid_o   = last_valid_reg;
    assign last_tag_o     = last_tag_reg;
    assign last_dest_o    = last_dest_reg;
    assign order_err_o    = order_err_reg;

endmodule

// File: tb/tb_commit_retire.sv
// Directed bench for commit_retire: vector table plus queue-full, flush and reset sequences.
module tb_commit_retire;
    import ooop_pkg::*;

    localparam int CNT_W = 32;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 flush_i;
    logic                 commit_valid_i;
    logic                 commit_ready_o;
    logic [ROB_TAG_W-1:0] commit_tag_i;
    logic                 commit_rd_used_i;
    logic [PREG_W-1:0]    commit_dest_new_i;
    logic [PREG_W-1:0]    commit_dest_old_i;
    logic                 free_valid_o;
    logic                 free_ready_i;
    logic [PREG_W-1:0]    free_tag_o;
    logic [CNT_W-1:0]     retire_count_o;
    logic                 last_valid_o;
    logic [ROB_TAG_W-1:0] last_tag_o;
    logic [PREG_W-1:0]    last_dest_o;
    logic                 order_err_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    commit_retire #(.FREE_Q_DEPTH(4), .CNT_W(CNT_W)) dut (
        .clk               (clk),
        .rst               (rst),
        .flush_i           (flush_i),
        .commit_valid_i    (commit_valid_i),
        .commit_ready_o    (commit_ready_o),
        .commit_tag_i      (commit_tag_i),
        .commit_rd_used_i  (commit_rd_used_i),
        .commit_dest_new_i (commit_dest_new_i),
        .commit_dest_old_i (commit_dest_old_i),
        .free_valid_o      (free_valid_o),
        .free_ready_i      (free_ready_i),
        .free_tag_o        (free_tag_o),
        .retire_count_o    (retire_count_o),
        .last_valid_o      (last_valid_o),
        .last_tag_o        (last_tag_o),
        .last_dest_o       (last_dest_o),
        .order_err_o       (order_err_o)
    );

    typedef struct {
        logic        flush;
        logic        valid;
        logic [4:0]  tag;
        logic        rd;
        logic [5:0]  dnew;
        logic [5:0]  dold;
        logic        fr;
        logic        e_ready;
        logic        e_fv;
        logic [5:0]  e_ft;
        logic [31:0] e_cnt;
        logic        e_lv;
        logic [4:0]  e_lt;
        logic [5:0]  e_ld;
        logic        e_err;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic fl, input logic v, input int tag, input logic rd,
                         input int dnew, input int dold, input logic fr);
        flush_i           = fl;
        commit_valid_i    = v;
        commit_tag_i      = ROB_TAG_W'(tag);
        commit_rd_used_i  = rd;
        commit_dest_new_i = PREG_W'(dnew);
        commit_dest_old_i = PREG_W'(dold);
        free_ready_i      = fr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
        chk("ready_during_rst", 32'(commit_ready_o), 0);
        rst = 1'b0;
        #1;
    endtask

    function automatic vec_t mk(input logic fl, input logic v, input int tag, input logic rd,
                                input int dnew, input int dold, input logic fr,
                                input logic er, input logic efv, input int eft, input int ecnt,
                                input logic elv, input int elt, input int eld, input logic eerr);
        vec_t r;
        r.flush = fl; r.valid = v; r.tag = 5'(tag); r.rd = rd;
        r.dnew = 6'(dnew); r.dold = 6'(dold); r.fr = fr;
        r.e_ready = er; r.e_fv = efv; r.e_ft = 6'(eft); r.e_cnt = 32'(ecnt);
        r.e_lv = elv; r.e_lt = 5'(elt); r.e_ld = 6'(eld); r.e_err = eerr;
        return r;
    endfunction

    initial begin
        //             fl v  tag rd new old fr | rdy fv ft cnt lv lt ld err
        vecs[0] = mk(0, 1, 0, 1, 33, 7,  1,   1, 1, 7,  1, 1, 0, 33, 0);
        vecs[1] = mk(0, 1, 1, 1, 34, 0,  1,   1, 0, 0,  2, 1, 1, 34, 0);
        vecs[2] = mk(0, 1, 2, 0, 50, 9,  1,   1, 0, 0,  3, 1, 2, 34, 0);
        vecs[3] = mk(0, 1, 3, 1, 40, 12, 0,   1, 1, 12, 4, 1, 3, 40, 0);
        vecs[4] = mk(0, 1, 5, 1, 41, 13, 0,   1, 1, 12, 5, 1, 5, 41, 1);
        vecs[5] = mk(0, 1, 6, 0, 0,  0,  1,   1, 1, 13, 6, 1, 6, 41, 1);
        vecs[6] = mk(1, 1, 9, 1, 55, 20, 0,   0, 1, 13, 6, 0, 6, 41, 1);
        vecs[7] = mk(0, 0, 0, 0, 0,  0,  1,   1, 0, 0,  6, 0, 6, 41, 1);
        vecs[8] = mk(0, 1, 0, 1, 2,  3,  0,   1, 1, 3,  7, 1, 0, 2,  1);
        vecs[9] = mk(0, 0, 0, 0, 0,  0,  1,   1, 0, 0,  7, 1, 0, 2,  1);

        do_reset();
        chk("rst_ready", 32'(commit_ready_o), 1);
        chk("rst_free_valid", 32'(free_valid_o), 0);
        chk("rst_free_tag", 32'(free_tag_o), 0);
        chk("rst_count", retire_count_o, 0);
        chk("rst_last_valid", 32'(last_valid_o), 0);
        chk("rst_last_tag", 32'(last_tag_o), 0);
        chk("rst_last_dest", 32'(last_dest_o), 0);
        chk("rst_order_err", 32'(order_err_o), 0);

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].flush, vecs[i].valid, int'(vecs[i].tag), vecs[i].rd,
                  int'(vecs[i].dnew), int'(vecs[i].dold), vecs[i].fr);
            #1;
            chk($sformatf("v%0d_ready", i), 32'(commit_ready_o), 32'(vecs[i].e_ready));
            step();
            chk($sformatf("v%0d_free_valid", i), 32'(free_valid_o), 32'(vecs[i].e_fv));
            chk($sformatf("v%0d_free_tag", i), 32'(free_tag_o), 32'(vecs[i].e_ft));
            chk($sformatf("v%0d_count", i), retire_count_o, vecs[i].e_cnt);
            chk($sformatf("v%0d_last_valid", i), 32'(last_valid_o), 32'(vecs[i].e_lv));
            chk($sformatf("v%0d_last_tag", i), 32'(last_tag_o), 32'(vecs[i].e_lt));
            chk($sformatf("v%0d_last_dest", i), 32'(last_dest_o), 32'(vecs[i].e_ld));
            chk($sformatf("v%0d_order_err", i), 32'(order_err_o), 32'(vecs[i].e_err));
            $display("vec %0d: ready=%0d fv=%0d ft=%0d cnt=%0d err=%0d", i, commit_ready_o,
                     free_valid_o, free_tag_o, retire_count_o, order_err_o);
        end

        // Fill the queue with p1..p4 while the free list stalls.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, i, 1, 40 + i, i + 1, 0);
            #1;
            chk($sformatf("fill%0d_ready", i), 32'(commit_ready_o), 1);
            step();
        end
        drive(0, 1, 4, 1, 44, 5, 0);
        #1;
        chk("full_ready", 32'(commit_ready_o), 0);
        step();
        chk("full_count", retire_count_o, 4);
        chk("full_hold_tag", 32'(free_tag_o), 1);
        drive(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain%0d_valid", i), 32'(free_valid_o), 1);
            chk($sformatf("drain%0d_tag", i), 32'(free_tag_o), 32'(i + 1));
            $display("drain %0d: tag=%0d", i, free_tag_o);
            step();
        end
        chk("drained_valid", 32'(free_valid_o), 0);

        // Flush with two frees pending: frees survive, order restarts at 0.
        do_reset();
        drive(0, 1, 0, 1, 10, 5, 0); step();
        drive(0, 1, 1, 1, 11, 6, 0); step();
        drive(1, 0, 0, 0, 0, 0, 0);  step();
        chk("flush_last_valid", 32'(last_valid_o), 0);
        chk("flush_count", retire_count_o, 2);
        drive(0, 1, 0, 0, 0, 0, 1);
        #1;
        chk("flush_tag0_ready", 32'(commit_ready_o), 1);
        chk("flush_head0", 32'(free_tag_o), 5);
        step();
        chk("flush_no_err", 32'(order_err_o), 0);
        chk("flush_head1", 32'(free_tag_o), 6);
        drive(0, 0, 0, 0, 0, 0, 1); step();
        chk("flush_drained", 32'(free_valid_o), 0);
        $display("flush seq: count=%0d err=%0d", retire_count_o, order_err_o);

        // Reset during drain of a full queue discards everything.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, i, 1, 20 + i, 8 + i, 0);
            step();
        end
        drive(0, 0, 0, 0, 0, 0, 1); step();
        chk("middrain_tag", 32'(free_tag_o), 9);
        do_reset();
        drive(0, 0, 0, 0, 0, 0, 1);
        #1;
        chk("midrst_free_valid", 32'(free_valid_o), 0);
        chk("midrst_count", retire_count_o, 0);
        chk("midrst_ready", 32'(commit_ready_o), 1);
        chk("midrst_last_valid", 32'(last_valid_o), 0);
        $display("midrst seq: fv=%0d cnt=%0d ready=%0d", free_valid_o, retire_count_o, commit_ready_o);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
